wb_stage_mp: RTL and testbench
==============================

WB_STAGE_MP -- requirements
Module: wb_stage_mp

Interface
REQ-001 SHALL provide parameter LANES, default 2, meaning instruction lanes per incoming bundle (1..4).
REQ-002 SHALL provide parameter RF_PORTS, default 1, meaning regfile write ports driven per cycle (1..LANES).
REQ-003 SHALL provide parameter DATA_W, default 32, meaning write data width; STRB_W=DATA_W/8.
REQ-004 SHALL provide parameter AW, default 5, meaning register address width; LANE_W=32+1+STRB_W+AW+DATA_W.
REQ-005 SHALL use one clock and a synchronous, active-high reset, in that port order:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
REQ-006 SHALL provide the remaining ports as follows:
- ws_allowin  out  1  stage can accept a bundle this cycle.
- ms_to_ws_valid  in  1  upstream bundle valid.
- ms_to_ws_bus  in  LANES*LANE_W  lane i at bits [i*LANE_W +: LANE_W], fields MSB-first {pc, lane_vld, strb, waddr, wdata}.
- ws_flush  in  1  discard the held bundle.
- ws_to_rf_bus  out  RF_PORTS*(STRB_W+AW+DATA_W)  port p is {strb, waddr, wdata}; strb=0 means no write.
- debug_wb_pc  out  RF_PORTS*32  pc of the lane on each port.
- debug_wb_rf_we  out  RF_PORTS*STRB_W  equals the port strb.
- debug_wb_rf_waddr  out  RF_PORTS*AW  port waddr.
- debug_wb_rf_wdata  out  RF_PORTS*DATA_W  port wdata.

Function
REQ-007 SHALL hold the bundle in registers ws_valid (1b) and pend (LANES-bit pending mask); no other control state.
REQ-008 SHALL capture the bundle when ms_to_ws_valid && ws_allowin && !ws_flush: ws_valid<=1; pend[i]<=lane_vld_i && strb_i!=0 && waddr_i!=0.
REQ-009 SHALL clear ws_valid when ws_allowin && !(ms_to_ws_valid && !ws_flush).
REQ-010 SHALL drive the regfile one cycle after capture at the earliest; no combinational path from ms_to_ws_bus to ws_to_rf_bus.
REQ-011 SHALL each cycle, when ws_valid && !ws_flush, scan pending lanes in ascending index and assign up to RF_PORTS lanes to ports 0,1,.. in scan order.
REQ-012 SHALL defer a pending lane whose waddr matches a lane already selected in the same cycle, and stop the scan at the first deferred lane, so same-register writes retire in lane order.
REQ-013 SHALL clear pend bits of issued lanes at the clock edge; unused ports SHALL output strb=0 with all other port fields 0.
REQ-014 SHALL compute ws_ready_go = (pend & ~issued_this_cycle)==0; ws_allowin = !ws_valid || ws_ready_go || ws_flush.
REQ-015 SHALL occupy one cycle for a bundle with pend==0, otherwise ceil(active/RF_PORTS) cycles plus one per REQ-012 deferral.
REQ-016 SHALL on ws_flush suppress all port writes that cycle, clear pend and ws_valid, and refuse capture that cycle (ws_allowin=1, no bundle taken).
REQ-017 SHALL accept back-to-back bundles: the final issue cycle of bundle N SHALL coincide with the capture of bundle N+1 without a bubble.
REQ-018 SHALL hold the captured bus contents stable while ws_valid && !ws_ready_go, regardless of ms_to_ws_bus.

Reset
REQ-019 SHALL while reset is high set ws_valid=0 and pend=0, drive all ws_to_rf_bus and debug strb fields to 0, and drive ws_allowin=1.
REQ-020 SHALL treat reset during a multi-cycle drain as an abort: no write from the aborted bundle appears after reset deasserts.
REQ-021 SHALL give reset priority over ws_flush and capture in the same cycle.

Verification
REQ-022 SHALL check LANES=2, RF_PORTS=1 with lanes {strb=F,waddr=3,wdata=0x11},{strb=F,waddr=4,wdata=0x22} -> port0 writes r3=0x11 at t+1 and r4=0x22 at t+2; ws_allowin=0 at t+1, 1 at t+2.
REQ-023 SHALL check RF_PORTS=2 with both lanes waddr=7, wdata 0xA then 0xB -> 0xA at t+1 on port0, 0xB at t+2 on port0, port1 strb=0 both cycles.
REQ-024 SHALL check lane1 waddr=0 with lane0 lane_vld=0 -> bundle drains in 1 cycle with no strb asserted on any port.
REQ-025 SHALL check a ws_flush pulse at t+1 during a 2-cycle drain -> no writes at t+1 or t+2, ws_valid=0 at t+2.
REQ-026 SHALL check continuous valid bundles at RF_PORTS=LANES=2 -> one bundle per cycle with no bubbles and ws_allowin held at 1.
REQ-027 SHALL check reset asserted at t+1 of a 2-lane/1-port drain -> all strb=0 and ws_allowin=1 from t+2 on, and lane1 is never written.

Source files
------------

// File: rtl/wb_stage_mp.sv
// Writeback stage: holds one multi-lane bundle and retires its pending lanes
// onto RF_PORTS regfile write ports, draining same-register writes in lane order.
module wb_lane_slot #(
  parameter int DATA_W = 32,
  parameter int AW     = 5,
  parameter int STRB_W = DATA_W/8,
  parameter int LANE_W = 32+1+STRB_W+AW+DATA_W
) (
  input  logic              clk,
  input  logic              cap,
  input  logic [LANE_W-1:0] lane_in,
  output logic              elig,
  output logic [31:0]       pc,
  output logic [STRB_W-1:0] strb,
  output logic [AW-1:0]     waddr,
  output logic [DATA_W-1:0] wdata
);
  localparam int VLD_B = DATA_W+AW+STRB_W;

  logic [LANE_W-2:0] lane_q;

  // Only lanes that really write a nonzero register ever become pending.
  assign elig = lane_in[VLD_B] && (lane_in[DATA_W+AW +: STRB_W] != '0)
                && (lane_in[DATA_W +: AW] != '0);

  always_ff @(posedge clk)
    if (cap) lane_q <= {lane_in[LANE_W-1 -: 32], lane_in[VLD_B-1:0]};

  assign {pc, strb, waddr, wdata} = lane_q;
endmodule

module wb_stage_mp #(
  parameter int LANES    = 2,
  parameter int RF_PORTS = 1,
  parameter int DATA_W   = 32,
  parameter int AW       = 5,
  parameter int STRB_W   = DATA_W/8,
  parameter int LANE_W   = 32+1+STRB_W+AW+DATA_W
) (
  input  logic                            clk,
  input  logic                            reset,
  output logic                            ws_allowin,
  input  logic                            ms_to_ws_valid,
  input  logic [LANES*LANE_W-1:0]         ms_to_ws_bus,
  input  logic                            ws_flush,
  output logic [RF_PORTS*(STRB_W+AW+DATA_W)-1:0] ws_to_rf_bus,
  output logic [RF_PORTS*32-1:0]          debug_wb_pc,
  output logic [RF_PORTS*STRB_W-1:0]      debug_wb_rf_we,
  output logic [RF_PORTS*AW-1:0]          debug_wb_rf_waddr,
  output logic [RF_PORTS*DATA_W-1:0]      debug_wb_rf_wdata
);
  localparam int PORT_W = STRB_W+AW+DATA_W;
  localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic                               ws_valid, ws_ready_go, cap, issue_en;
  logic                               stop, clash, placed;
  logic [LANES-1:0]                   pend, elig, issued;
  logic [LANES-1:0][31:0]             l_pc;
  logic [LANES-1:0][STRB_W-1:0]       l_strb;
  logic [LANES-1:0][AW-1:0]           l_waddr;
  logic [LANES-1:0][DATA_W-1:0]       l_wdata;
  logic [RF_PORTS-1:0]                port_vld;
  logic [RF_PORTS-1:0][LIDX_W-1:0]    port_lane;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    wb_lane_slot #(.DATA_W(DATA_W), .AW(AW), .STRB_W(STRB_W), .LANE_W(LANE_W)) u_slot (
      .clk     (clk),
      .cap     (cap),
      .lane_in (ms_to_ws_bus[g*LANE_W +: LANE_W]),
      .elig    (elig[g]),
      .pc      (l_pc[g]),
      .strb    (l_strb[g]),
      .waddr   (l_waddr[g]),
      .wdata   (l_wdata[g])
    );
  end

  assign issue_en    = ws_valid && !ws_flush && !reset;
  assign ws_ready_go = ((pend & ~issued) == '0);
  assign ws_allowin  = reset || !ws_valid || ws_ready_go || ws_flush;
  assign cap         = ms_to_ws_valid && ws_allowin && !ws_flush && !reset;

  // In-order scan: a lane hitting a full port set or a same-cycle waddr clash
  // halts the scan so later lanes never overtake it.
  always_comb begin
    issued    = '0;
    port_vld  = '0;
    port_lane = '0;
    stop      = 1'b0;
    clash     = 1'b0;
    placed    = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      clash = 1'b0;
      for (int j = 0; j < i; j++)
        if (issued[j] && (l_waddr[j] == l_waddr[i])) clash = 1'b1;
      if (issue_en && pend[i] && !stop) begin
        if (clash || port_vld[RF_PORTS-1]) stop = 1'b1;
        else begin
          placed = 1'b0;
          for (int p = 0; p < RF_PORTS; p++)
            if (!placed && !port_vld[p]) begin
              port_vld[p]  = 1'b1;
              port_lane[p] = LIDX_W'(i);
              placed       = 1'b1;
            end
          issued[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ws_to_rf_bus      = '0;
    debug_wb_pc       = '0;
    debug_wb_rf_we    = '0;
    debug_wb_rf_waddr = '0;
    debug_wb_rf_wdata = '0;
    for (int p = 0; p < RF_PORTS; p++)
      for (int i = 0; i < LANES; i++)
        if (port_vld[p] && (port_lane[p] == LIDX_W'(i))) begin
          ws_to_rf_bus[p*PORT_W +: PORT_W]      = {l_strb[i], l_waddr[i], l_wdata[i]};
          debug_wb_pc[p*32 +: 32]               = l_pc[i];
          debug_wb_rf_we[p*STRB_W +: STRB_W]    = l_strb[i];
          debug_wb_rf_waddr[p*AW +: AW]         = l_waddr[i];
          debug_wb_rf_wdata[p*DATA_W +: DATA_W] = l_wdata[i];
        end
  end

  always_ff @(posedge clk) begin
    if (reset || ws_flush) begin
      ws_valid <= 1'b0;
      pend     <= '0;
    end else if (cap) begin
      ws_valid <= 1'b1;
      pend     <= elig;
    end else begin
      pend <= pend & ~issued;
      if (ws_allowin) ws_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_wb_stage_mp.sv
// Bench for wb_stage_mp: a 2-lane/1-port and a 2-lane/2-port instance checked
// every cycle against a lane-list model, plus directed scenario checks.
module tb_wb_stage_mp;
  localparam int L = 2, SW = 4, AW = 5, DW = 32;
  localparam int LW = 32+1+SW+AW+DW, PW = SW+AW+DW;

  typedef struct packed {
    logic [31:0]   pc;
    logic          vld;
    logic [SW-1:0] strb;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
  } lane_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lane_t in_l [2][L];
  logic  in_v [2];
  logic  in_f [2];

  logic [L*LW-1:0] bus_a, bus_b;
  assign bus_a = {in_l[0][1], in_l[0][0]};
  assign bus_b = {in_l[1][1], in_l[1][0]};

  logic          allow_a, allow_b;
  logic [PW-1:0] ra;
  logic [31:0]   pca;
  logic [SW-1:0] wea;
  logic [AW-1:0] waa;
  logic [DW-1:0] wda;
  logic [2*PW-1:0] rb;
  logic [63:0]     pcb;
  logic [2*SW-1:0] web;
  logic [2*AW-1:0] wab;
  logic [2*DW-1:0] wdb;

  wb_stage_mp #(.LANES(2), .RF_PORTS(1), .DATA_W(DW), .AW(AW)) dut_a (
    .clk(clk), .reset(reset), .ws_allowin(allow_a), .ms_to_ws_valid(in_v[0]),
    .ms_to_ws_bus(bus_a), .ws_flush(in_f[0]), .ws_to_rf_bus(ra),
    .debug_wb_pc(pca), .debug_wb_rf_we(wea), .debug_wb_rf_waddr(waa),
    .debug_wb_rf_wdata(wda));

  wb_stage_mp #(.LANES(2), .RF_PORTS(2), .DATA_W(DW), .AW(AW)) dut_b (
    .clk(clk), .reset(reset), .ws_allowin(allow_b), .ms_to_ws_valid(in_v[1]),
    .ms_to_ws_bus(bus_b), .ws_flush(in_f[1]), .ws_to_rf_bus(rb),
    .debug_wb_pc(pcb), .debug_wb_rf_we(web), .debug_wb_rf_waddr(wab),
    .debug_wb_rf_wdata(wdb));

  int checks = 0, errors = 0, cyc_n = 0;

  // Model: held lanes plus a per-lane "still owes a write" flag.
  lane_t         m_lane [2][L];
  logic          m_valid [2];
  logic [L-1:0]  m_pend [2];
  int            pick [2][2];
  int            npick [2];
  logic [PW-1:0] e_port [2][2];
  logic [31:0]   e_pc [2][2];
  logic          e_allow [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc_n);
    end
  endtask

  function automatic lane_t mk(input logic [31:0] pc, input logic v, input logic [SW-1:0] s,
                               input logic [AW-1:0] a, input logic [DW-1:0] d);
    lane_t x;
    x.pc = pc; x.vld = v; x.strb = s; x.waddr = a; x.wdata = d;
    return x;
  endfunction

  function automatic lane_t rnd_lane();
    lane_t x;
    x.pc    = $urandom;
    x.vld   = ($urandom_range(0, 7) != 0);
    x.strb  = ($urandom_range(0, 5) == 0) ? '0 : SW'($urandom);
    x.waddr = AW'($urandom_range(0, 3));
    x.wdata = $urandom;
    return x;
  endfunction

  task automatic model_eval(input int d, input int np);
    int rem;
    bit clash;
    npick[d] = 0;
    for (int p = 0; p < 2; p++) begin e_port[d][p] = '0; e_pc[d][p] = '0; end
    if (!reset && m_valid[d] && !in_f[d])
      for (int i = 0; i < L; i++)
        if (m_pend[d][i]) begin
          clash = 0;
          for (int k = 0; k < npick[d]; k++)
            if (m_lane[d][pick[d][k]].waddr == m_lane[d][i].waddr) clash = 1;
          if (clash || npick[d] == np) break;
          pick[d][npick[d]]   = i;
          e_port[d][npick[d]] = {m_lane[d][i].strb, m_lane[d][i].waddr, m_lane[d][i].wdata};
          e_pc[d][npick[d]]   = m_lane[d][i].pc;
          npick[d]++;
        end
    rem = 0;
    for (int i = 0; i < L; i++) if (m_pend[d][i]) rem++;
    rem -= npick[d];
    e_allow[d] = reset || !m_valid[d] || (rem == 0) || in_f[d];
  endtask

  task automatic model_commit(input int d);
    if (reset || in_f[d]) begin
      m_valid[d] = 0; m_pend[d] = '0;
    end else if (in_v[d] && e_allow[d]) begin
      m_valid[d] = 1;
      for (int i = 0; i < L; i++) begin
        m_lane[d][i] = in_l[d][i];
        m_pend[d][i] = in_l[d][i].vld && (in_l[d][i].strb != 0) && (in_l[d][i].waddr != 0);
      end
    end else begin
      for (int k = 0; k < npick[d]; k++) m_pend[d][pick[d][k]] = 1'b0;
      if (e_allow[d]) m_valid[d] = 0;
    end
  endtask

  task automatic check_now();
    @(negedge clk);
    model_eval(0, 1);
    model_eval(1, 2);
    chk("a_allow", allow_a, e_allow[0]);
    chk("a_port0", ra, e_port[0][0]);
    chk("a_pc0", pca, e_pc[0][0]);
    chk("a_we0", wea, e_port[0][0][PW-1 -: SW]);
    chk("a_waddr0", waa, e_port[0][0][DW +: AW]);
    chk("a_wdata0", wda, e_port[0][0][DW-1:0]);
    chk("b_allow", allow_b, e_allow[1]);
    for (int p = 0; p < 2; p++) begin
      chk("b_port", rb[p*PW +: PW], e_port[1][p]);
      chk("b_pc", pcb[p*32 +: 32], e_pc[1][p]);
      chk("b_we", web[p*SW +: SW], e_port[1][p][PW-1 -: SW]);
      chk("b_waddr", wab[p*AW +: AW], e_port[1][p][DW +: AW]);
      chk("b_wdata", wdb[p*DW +: DW], e_port[1][p][DW-1:0]);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    model_commit(0);
    model_commit(1);
    cyc_n++;
    #1;
  endtask

  task automatic idle(input int n);
    in_v[0] = 0; in_v[1] = 0; in_f[0] = 0; in_f[1] = 0;
    repeat (n) begin check_now(); adv(); end
  endtask

  initial begin
    reset = 1;
    for (int d = 0; d < 2; d++) begin
      in_v[d] = 0; in_f[d] = 0; m_valid[d] = 0; m_pend[d] = '0;
      for (int i = 0; i < L; i++) begin in_l[d][i] = '0; m_lane[d][i] = '0; end
    end
    @(posedge clk); #1;
    check_now();
    chk("rst_allow", allow_a, 1'b1);
    chk("rst_strb", wea, '0);
    adv();
    reset = 0;
    idle(2);

    // Two lanes, one port: r3 then r4, stage stalls one cycle.
    in_l[0][0] = mk(32'h100, 1, 4'hF, 5'd3, 32'h11);
    in_l[0][1] = mk(32'h104, 1, 4'hF, 5'd4, 32'h22);
    in_v[0] = 1; check_now(); adv(); in_v[0] = 0;
    check_now();
    chk("r22_t1_port", ra, {4'hF, 5'd3, 32'h11});
    chk("r22_t1_allow", allow_a, 1'b0);
    adv(); check_now();
    chk("r22_t2_port", ra, {4'hF, 5'd4, 32'h22});
    chk("r22_t2_allow", allow_a, 1'b1);
    adv(); idle(2);

    // Two ports, same waddr: second write deferred a cycle.
    in_l[1][0] = mk(32'h200, 1, 4'hF, 5'd7, 32'hA);
    in_l[1][1] = mk(32'h204, 1, 4'hF, 5'd7, 32'hB);
    in_v[1] = 1; check_now(); adv(); in_v[1] = 0;
    check_now();
    chk("r23_t1_p0", rb[PW-1:0], {4'hF, 5'd7, 32'hA});
    chk("r23_t1_p1strb", rb[2*PW-1 -: SW], '0);
    adv(); check_now();
    chk("r23_t2_p0", rb[PW-1:0], {4'hF, 5'd7, 32'hB});
    chk("r23_t2_p1strb", rb[2*PW-1 -: SW], '0);
    adv(); idle(2);

    // Nothing pending: one-cycle bundle with no writes.
    in_l[0][0] = mk(32'h300, 0, 4'hF, 5'd5, 32'h33);
    in_l[0][1] = mk(32'h304, 1, 4'hF, 5'd0, 32'h44);
    in_v[0] = 1; check_now(); adv(); in_v[0] = 0;
    check_now();
    chk("r24_strb", wea, '0);
    chk("r24_allow", allow_a, 1'b1);
    adv(); idle(2);

    // Flush in the middle of a two-cycle drain.
    in_l[0][0] = mk(32'h400, 1, 4'hF, 5'd3, 32'h11);
    in_l[0][1] = mk(32'h404, 1, 4'hF, 5'd4, 32'h22);
    in_v[0] = 1; check_now(); adv(); in_v[0] = 0;
    in_f[0] = 1; check_now();
    chk("r25_t1_strb", wea, '0);
    chk("r25_t1_allow", allow_a, 1'b1);
    adv(); in_f[0] = 0; check_now();
    chk("r25_t2_strb", wea, '0);
    chk("r25_t2_valid", dut_a.ws_valid, 1'b0);
    adv(); idle(2);

    // Back-to-back bundles on the 2-port instance.
    for (int k = 0; k < 6; k++) begin
      in_l[1][0] = mk(32'h500 + k*8, 1, 4'hF, AW'(2*k+1), $urandom);
      in_l[1][1] = mk(32'h504 + k*8, 1, 4'h3, AW'(2*k+2), $urandom);
      in_v[1] = 1; check_now();
      chk("r26_allow", allow_b, 1'b1);
      if (k > 0) chk("r26_strbs", web, {4'h3, 4'hF});
      adv();
    end
    in_v[1] = 0; check_now();
    chk("r26_last_strbs", web, {4'h3, 4'hF});
    adv(); idle(2);

    // Reset mid-drain aborts lane1.
    in_l[0][0] = mk(32'h600, 1, 4'hF, 5'd3, 32'h11);
    in_l[0][1] = mk(32'h604, 1, 4'hF, 5'd9, 32'h99);
    in_v[0] = 1; check_now(); adv(); in_v[0] = 0;
    reset = 1; check_now(); adv(); reset = 0;
    for (int k = 0; k < 3; k++) begin
      check_now();
      chk("r27_strb", wea, '0);
      chk("r27_allow", allow_a, 1'b1);
      adv();
    end

    // Randomized traffic with frequent waddr clashes, flushes and resets.
    for (int n = 0; n < 400; n++) begin
      for (int d = 0; d < 2; d++) begin
        in_v[d] = ($urandom_range(0, 9) < 7);
        in_f[d] = ($urandom_range(0, 9) == 0);
        for (int i = 0; i < L; i++) in_l[d][i] = rnd_lane();
      end
      reset = ($urandom_range(0, 49) == 0);
      check_now();
      adv();
    end
    reset = 0;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
